// File: rtl/mat_mult_pkg.sv
// Shared types and width helpers for the sequential N x N matrix multiplier.
// MAT_MULT_SIGNED_EN (see mat_mac_unit) does not change anything declared here.
package mat_mult_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        EMIT    = 2'd2
    } state_e;

    // Sum of N full-precision products never needs more than log2(N) extra bits.
    function automatic int acc_width(input int n, input int data_w);
        return 2 * data_w + $clog2(n);
    endfunction

    function automatic int idx_width(input int n);
        return $clog2(n * n);
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mat_mult_seq_if.sv
// Operand-in / result-out valid-ready bundle for mat_mult_seq.
interface mat_mult_seq_if #(
    parameter int N      = 3,
    parameter int DATA_W = 8
);
    import mat_mult_pkg::*;

    localparam int ACC_W = acc_width(N, DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_last;
    logic              busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );

endinterface

// File: rtl/mat_mac_unit.sv
// Registered multiply-accumulate; first_i restarts the sum with the current product.
// MAT_MULT_SIGNED_EN selects two's-complement operands, otherwise unsigned.
module mat_mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              first_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  sum_o
);

    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // Extending both operands to ACC_W keeps the low ACC_W product bits exact in either mode.
`ifdef MAT_MULT_SIGNED_EN
    assign a_ext = {{(ACC_W-DATA_W){a_i[DATA_W-1]}}, a_i};
    assign b_ext = {{(ACC_W-DATA_W){b_i[DATA_W-1]}}, b_i};
`else
    assign a_ext = {{(ACC_W-DATA_W){1'b0}}, a_i};
    assign b_ext = {{(ACC_W-DATA_W){1'b0}}, b_i};
`endif

    assign prod  = a_ext * b_ext;
    assign acc_d = (first_i ? '0 : acc_q) + prod;
    assign sum_o = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential C = A x B over one shared MAC; operands and results stream row-major.
// Build option MAT_MULT_SIGNED_EN (in mat_mac_unit) switches to two's-complement math.
//
//   state   | meaning
//   LOAD    | accept N*N beats of A/B into the operand arrays
//   COMPUTE | one MAC per cycle over k for element C[i][j]
//   EMIT    | hold C[i][j] on the output until the sink takes it
module mat_mult_seq
    import mat_mult_pkg::*;
#(
    parameter int N      = 3,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mat_mult_seq_if.slave       bus_if
);

    localparam int ACC_W = acc_width(N, DATA_W);
    localparam int CW    = cnt_width(N);
    localparam int AW    = idx_width(N);

    localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
    localparam logic [AW-1:0] LAST_BEAT = AW'(N * N - 1);
    localparam logic [AW-1:0] N_AW      = AW'(N);

    state_e            state_q, state_d;
    logic [AW-1:0]     beat_q, beat_d;
    logic [CW-1:0]     i_q, i_d;
    logic [CW-1:0]     j_q, j_d;
    logic [CW-1:0]     k_q, k_d;
    logic              in_rdy_q, in_rdy_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [ACC_W-1:0]  out_data_q, out_data_d;

    logic              wr_en;
    logic              mac_en;
    logic [ACC_W-1:0]  mac_sum;
    logic [AW-1:0]     a_addr;
    logic [AW-1:0]     b_addr;

    logic [DATA_W-1:0] a_mem [N*N];
    logic [DATA_W-1:0] b_mem [N*N];

    // Operand arrays hold no reset value; only beats accepted in LOAD are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            a_mem[beat_q] <= bus_if.in_a;
            b_mem[beat_q] <= bus_if.in_b;
        end
    end

    assign a_addr = AW'(i_q) * N_AW + AW'(k_q);
    assign b_addr = AW'(k_q) * N_AW + AW'(j_q);

    mat_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (mac_en),
        .first_i (k_q == '0),
        .a_i     (a_mem[a_addr]),
        .b_i     (b_mem[b_addr]),
        .sum_o   (mac_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            beat_q      <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            in_rdy_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            in_rdy_q    <= in_rdy_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        wr_en       = 1'b0;
        mac_en      = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (bus_if.in_valid && in_rdy_q) begin
                    wr_en = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = COMPUTE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                mac_en = 1'b1;
                if (k_q == LAST_IDX) begin
                    // Final sum goes straight from the MAC adder into the output register.
                    out_data_d  = mac_sum;
                    out_valid_d = 1'b1;
                    out_last_d  = (i_q == LAST_IDX) && (j_q == LAST_IDX);
                    k_d         = '0;
                    state_d     = EMIT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            EMIT: begin
                if (bus_if.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        i_d     = '0;
                        j_d     = '0;
                        state_d = LOAD;
                    end else begin
                        if (j_q == LAST_IDX) begin
                            j_d = '0;
                            i_d = i_q + 1'b1;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                        state_d = COMPUTE;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Registered ready: it follows the state that will be current next cycle.
    assign in_rdy_d = (state_d == LOAD);

    assign bus_if.in_ready  = in_rdy_q;
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.out_data  = out_data_q;
    assign bus_if.out_last  = out_last_q;
    assign bus_if.busy      = (state_q != LOAD) || (beat_q != '0);

endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed bench for mat_mult_seq (N=3, DATA_W=8); honours MAT_MULT_SIGNED_EN expectations.
module tb_mat_mult_seq;
   import mat_mult_pkg::*;

   localparam int N  = 3;
   localparam int DW = 8;
   localparam int AC = acc_width(N, DW);

`ifdef MAT_MULT_SIGNED_EN
   localparam logic [AC-1:0] EXP_MAX = AC'(3);
   localparam logic [AC-1:0] EXP_MIX = AC'(-48768);
`else
   localparam logic [AC-1:0] EXP_MAX = AC'(195075);
   localparam logic [AC-1:0] EXP_MIX = AC'(48768);
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   mat_mult_seq_if #(.N(N), .DATA_W(DW)) bus ();

   mat_mult_seq #(.N(N), .DATA_W(DW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bus.slave)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] ma [9];
   logic [DW-1:0] mb [9];
   logic [AC-1:0] exp_c [9];

   task automatic chk(input string tag, input bit ok, input longint obs, input longint expv);
      checks++;
      if (!ok) begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic [AC-1:0] model(input int r, input int c);
      int acc = 0;
      for (int m = 0; m < N; m++) begin
`ifdef MAT_MULT_SIGNED_EN
         acc += int'($signed(ma[r*N+m])) * int'($signed(mb[m*N+c]));
`else
         acc += int'(ma[r*N+m]) * int'(mb[m*N+c]);
`endif
      end
      return AC'(acc);
   endfunction

   task automatic load(input int gap_at, input int gap_len);
      int guard;
      for (int k = 0; k < N*N; k++) begin
         if (k == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               bus.in_valid = 1'b0;
               @(negedge clk);
               chk("busy_gap", bus.busy === 1'b1, bus.busy, 1);
            end
         end
         bus.in_valid = 1'b1;
         bus.in_a     = ma[k];
         bus.in_b     = mb[k];
         guard = 0;
         while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 20) chk("in_ready_timeout", guard === 0, guard, 0);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic collect(input bit bp);
      int   got = 0;
      int   guard = 0;
      logic stalled = 1'b0;
      logic [AC-1:0] held = '0;
      logic exp_last;
      while (got < N*N && guard < 600) begin
         if (bp) begin
            bus.out_ready = (guard % 3 == 0);
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_a      = DW'($urandom);
            bus.in_b      = DW'($urandom);
            chk("in_ready_low", bus.in_ready === 1'b0, bus.in_ready, 0);
         end else begin
            bus.out_ready = 1'b1;
         end
         if (bus.out_valid) begin
            if (stalled) chk("stall_stable", bus.out_data === held, bus.out_data, held);
            if (bus.out_ready) begin
               chk($sformatf("c%0d", got), bus.out_data === exp_c[got], bus.out_data, exp_c[got]);
               exp_last = (got == N*N-1) ? 1'b1 : 1'b0;
               chk($sformatf("last%0d", got), bus.out_last === exp_last, bus.out_last, exp_last);
               got++;
               stalled = 1'b0;
            end else begin
               held    = bus.out_data;
               stalled = 1'b1;
            end
         end
         @(negedge clk);
         guard++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("n_results", got === N*N, got, N*N);
      chk("in_ready_after", bus.in_ready === 1'b1, bus.in_ready, 1);
      chk("busy_after", bus.busy === 1'b0, bus.busy, 0);
      chk("out_valid_after", bus.out_valid === 1'b0, bus.out_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int g;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_out_valid", bus.out_valid === 1'b0, bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready === 1'b0, bus.in_ready, 0);
      chk("rst_out_data", bus.out_data === AC'(0), bus.out_data, 0);
      chk("rst_out_last", bus.out_last === 1'b0, bus.out_last, 0);
      chk("rst_busy", bus.busy === 1'b0, bus.busy, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", bus.in_ready === 1'b1, bus.in_ready, 1);

      // Identity A, B = 1..9, plus first-result latency
      for (int k = 0; k < 9; k++) begin
         ma[k]    = (k % 4 == 0) ? 8'd1 : 8'd0;
         mb[k]    = DW'(k + 1);
         exp_c[k] = AC'(k + 1);
      end
      load(-1, 0);
      chk("busy_compute", bus.busy === 1'b1, bus.busy, 1);
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat === 4, lat, 4);
      collect(1'b0);

      // All-ones operands: widest result
      for (int k = 0; k < 9; k++) begin
         ma[k] = 8'hFF; mb[k] = 8'hFF; exp_c[k] = EXP_MAX;
      end
      load(-1, 0);
      collect(1'b0);

      // Backpressure with junk input traffic
      for (int k = 0; k < 9; k++) begin
         ma[k] = DW'(k + 1);
         mb[k] = DW'(9 - k);
      end
      exp_c[0] = AC'(30);  exp_c[1] = AC'(24);  exp_c[2] = AC'(18);
      exp_c[3] = AC'(84);  exp_c[4] = AC'(69);  exp_c[5] = AC'(54);
      exp_c[6] = AC'(138); exp_c[7] = AC'(114); exp_c[8] = AC'(90);
      load(-1, 0);
      collect(1'b1);

      // Input gap between beats 4 and 5
      ma[0] = 2; ma[1] = 0; ma[2] = 1; ma[3] = 3; ma[4] = 1; ma[5] = 0; ma[6] = 0; ma[7] = 4; ma[8] = 5;
      mb[0] = 1; mb[1] = 2; mb[2] = 3; mb[3] = 0; mb[4] = 1; mb[5] = 0; mb[6] = 4; mb[7] = 0; mb[8] = 2;
      for (int k = 0; k < 9; k++) exp_c[k] = model(k / N, k % N);
      load(5, 5);
      collect(1'b0);

      // Sign-sensitive operands: 0x80 x 0x7F
      for (int k = 0; k < 9; k++) begin
         ma[k] = 8'h80; mb[k] = 8'h7F; exp_c[k] = EXP_MIX;
      end
      load(-1, 0);
      collect(1'b0);

      // Reset during the second EMIT, then reload A = B = I
      for (int k = 0; k < 9; k++) begin
         ma[k] = DW'(k + 1);
         mb[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
      end
      load(-1, 0);
      g = 0;
      while (!bus.out_valid && g < 20) begin @(negedge clk); g++; end
      chk("emit1_seen", bus.out_valid === 1'b1, bus.out_valid, 1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      g = 0;
      while (!bus.out_valid && g < 20) begin @(negedge clk); g++; end
      chk("emit2_seen", bus.out_valid === 1'b1, bus.out_valid, 1);
      chk("emit2_data", bus.out_data === AC'(2), bus.out_data, 2);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", bus.out_valid === 1'b0, bus.out_valid, 0);
      chk("abort_in_ready", bus.in_ready === 1'b0, bus.in_ready, 0);
      chk("abort_busy", bus.busy === 1'b0, bus.busy, 0);
      chk("abort_out_data", bus.out_data === AC'(0), bus.out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rerel_in_ready", bus.in_ready === 1'b1, bus.in_ready, 1);
      for (int k = 0; k < 9; k++) begin
         ma[k]    = (k % 4 == 0) ? 8'd1 : 8'd0;
         mb[k]    = ma[k];
         exp_c[k] = (k % 4 == 0) ? AC'(1) : AC'(0);
      end
      load(-1, 0);
      collect(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
